matrix_writeback: RTL and testbench

Downstream stage of the Transposition ALU. It collects the four transposed rows (NewRow1..NewRow4) that the ALU presents on successive Done pulses into a 4x4 buffer. It then writes the 16 elements to data memory in row-major order through a ready/valid write port, and reports completion, upstream error and overrun to the CPU control path.

---
 rtl/matrix_writeback.sv | 93 +++++++++
 tb/tb_matrix_writeback.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/matrix_writeback.sv
// matrix_writeback: gathers four transposed rows into a 4x4 buffer and writes them row-major to memory
//   Clock       rising-edge clock
//   ClearAll    asynchronous active-high reset
//   Done        row strobe, NewRow1..4 carry elements 0..3 of one row
//   Error       upstream error strobe, aborts collection
//   BaseAddress address of element [0][0], sampled with row 0
//   MemReady    memory accepts the presented word
//   Ready       high while rows can be captured
//   MemWrite    write request with MemAddress/MemData
//   WriteDone   one-cycle pulse after the 16th word
//   WriteError  one-cycle pulse after an abort
//   Overrun     sticky, a row arrived while not Ready
module matrix_writeback #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clock,
  input  logic                  ClearAll,
  input  logic                  Done,
  input  logic                  Error,
  input  logic [DATA_WIDTH-1:0] NewRow1,
  input  logic [DATA_WIDTH-1:0] NewRow2,
  input  logic [DATA_WIDTH-1:0] NewRow3,
  input  logic [DATA_WIDTH-1:0] NewRow4,
  input  logic [ADDR_WIDTH-1:0] BaseAddress,
  input  logic                  MemReady,
  output logic                  Ready,
  output logic                  MemWrite,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic [DATA_WIDTH-1:0] MemData,
  output logic                  WriteDone,
  output logic                  WriteError,
  output logic                  Overrun
);
  typedef enum logic [1:0] {COLLECT, WRITE, FINISH, ABORT} state_t;
  state_t state, next_state;
  logic [1:0] row_count;
  logic [3:0] word_count;
  logic [ADDR_WIDTH-1:0] base;
  logic [DATA_WIDTH-1:0] buffer [16];
  logic capture, last_row, xfer;
  logic [3:0] next_word;
  assign capture   = state == COLLECT && Done && !Error;
  assign last_row  = capture && row_count == 2'd3;
  assign xfer      = MemWrite && MemReady;
  assign next_word = word_count + 4'd1;
  always_ff @(posedge Clock or posedge ClearAll)
    if (ClearAll) state <= COLLECT;
    else state <= next_state;
  always_comb
    next_state = state == COLLECT ? (Error ? ABORT : last_row ? WRITE : COLLECT)
               : state == WRITE   ? (xfer && word_count == 4'd15 ? FINISH : WRITE)
               : COLLECT;
  always_comb Ready = state == COLLECT;
  always_ff @(posedge Clock)
    if (capture) begin
      buffer[{row_count, 2'd0}] <= NewRow1;
      buffer[{row_count, 2'd1}] <= NewRow2;
      buffer[{row_count, 2'd2}] <= NewRow3;
      buffer[{row_count, 2'd3}] <= NewRow4;
    end
  // Bus registers are loaded one edge ahead so the word in flight stays put until MemReady.
  always_ff @(posedge Clock or posedge ClearAll)
    if (ClearAll) begin
      row_count  <= '0;
      word_count <= '0;
      base       <= '0;
      MemWrite   <= 1'b0;
      MemAddress <= '0;
      MemData    <= '0;
      WriteDone  <= 1'b0;
      WriteError <= 1'b0;
      Overrun    <= 1'b0;
    end else begin
      WriteDone  <= next_state == FINISH;
      WriteError <= next_state == ABORT;
      if (Done && state != COLLECT) Overrun <= 1'b1;
      if (capture) row_count <= row_count + 2'd1;
      if (capture && row_count == 2'd0) base <= BaseAddress;
      if ((state == COLLECT && Error) || state == FINISH) row_count <= '0;
      if (last_row) begin
        MemWrite   <= 1'b1;
        word_count <= '0;
        MemAddress <= base;
        MemData    <= buffer[0];
      end else if (xfer) begin
        word_count <= next_word;
        MemAddress <= base + ADDR_WIDTH'(next_word);
        MemData    <= buffer[next_word];
        if (word_count == 4'd15) MemWrite <= 1'b0;
      end
    end
endmodule

// File: tb/tb_matrix_writeback.sv
// tb_matrix_writeback: directed table-driven check of collection, write-out, abort, overrun and reset
module tb_matrix_writeback;
  localparam int AW = 8;
  localparam int DW = 32;
  logic Clock = 1'b0;
  logic ClearAll, Done, Error, MemReady;
  logic [DW-1:0] NewRow1, NewRow2, NewRow3, NewRow4;
  logic [AW-1:0] BaseAddress;
  logic Ready, MemWrite, WriteDone, WriteError, Overrun;
  logic [AW-1:0] MemAddress;
  logic [DW-1:0] MemData;
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0]  base;
    int          start;
    logic [15:0] pat;
    int          done_at;
    int          err_at;
    logic        overrun;
  } vec_t;
  vec_t vecs [4];

  matrix_writeback #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .Clock(Clock), .ClearAll(ClearAll), .Done(Done), .Error(Error),
    .NewRow1(NewRow1), .NewRow2(NewRow2), .NewRow3(NewRow3), .NewRow4(NewRow4),
    .BaseAddress(BaseAddress), .MemReady(MemReady), .Ready(Ready),
    .MemWrite(MemWrite), .MemAddress(MemAddress), .MemData(MemData),
    .WriteDone(WriteDone), .WriteError(WriteError), .Overrun(Overrun)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge Clock);
    #1;
  endtask

  task automatic set_row(input int first);
    NewRow1 = DW'(first);
    NewRow2 = DW'(first + 1);
    NewRow3 = DW'(first + 2);
    NewRow4 = DW'(first + 3);
  endtask

  task automatic send_rows(input logic [7:0] base, input int start);
    for (int r = 0; r < 4; r++) begin
      Done = 1'b1;
      BaseAddress = r == 0 ? base : 8'h55;
      set_row(start + 4 * r);
      step;
      if (r < 3) begin
        check("ready_collect", 32'(Ready), 32'd1);
        check("idle_no_write", 32'(MemWrite), 32'd0);
      end
    end
    Done = 1'b0;
    check("first_write", 32'(MemWrite), 32'd1);
    check("first_addr", 32'(MemAddress), 32'(base));
    check("first_data", 32'(MemData), 32'(start));
    check("ready_low_write", 32'(Ready), 32'd0);
  endtask

  task automatic run_write(input logic [7:0] base, input int start, input logic [15:0] pat,
                           input int done_at, input int err_at);
    int n;
    int c;
    logic mw;
    n = 0;
    c = 0;
    while (n < 16 && c < 100) begin
      MemReady = pat[c % 16];
      Done = c == done_at;
      Error = c == err_at;
      set_row(999);
      BaseAddress = 8'hAA;
      check("mem_write", 32'(MemWrite), 32'd1);
      check("addr", 32'(MemAddress), 32'(8'(base + 8'(n))));
      check("data", 32'(MemData), 32'(start + n));
      check("no_write_error", 32'(WriteError), 32'd0);
      mw = MemWrite;
      step;
      if (mw && MemReady) n++;
      c++;
    end
    Done = 1'b0;
    Error = 1'b0;
    MemReady = 1'b0;
    check("transfers", 32'(n), 32'd16);
    check("done_pulse", 32'(WriteDone), 32'd1);
    check("write_off", 32'(MemWrite), 32'd0);
    check("ready_finish", 32'(Ready), 32'd0);
    step;
    check("done_clear", 32'(WriteDone), 32'd0);
    check("ready_back", 32'(Ready), 32'd1);
  endtask

  initial begin
    int w;
    ClearAll = 1'b1;
    Done = 1'b0;
    Error = 1'b0;
    MemReady = 1'b0;
    set_row(0);
    BaseAddress = '0;
    #12;
    check("rst_ready", 32'(Ready), 32'd1);
    check("rst_write", 32'(MemWrite), 32'd0);
    check("rst_addr", 32'(MemAddress), 32'd0);
    check("rst_data", MemData, 32'd0);
    check("rst_done", 32'(WriteDone), 32'd0);
    check("rst_err", 32'(WriteError), 32'd0);
    check("rst_ovr", 32'(Overrun), 32'd0);
    ClearAll = 1'b0;
    step;

    vecs[0] = '{8'h20, 1,   16'hFFFF, -1, -1, 1'b0};
    vecs[1] = '{8'h20, 1,   16'h9999, -1, -1, 1'b0};
    vecs[2] = '{8'hF8, 100, 16'hFFFF, -1, 3,  1'b0};
    vecs[3] = '{8'h20, 1,   16'hFFFF, 1,  -1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      send_rows(vecs[i].base, vecs[i].start);
      run_write(vecs[i].base, vecs[i].start, vecs[i].pat, vecs[i].done_at, vecs[i].err_at);
      check("overrun", 32'(Overrun), 32'(vecs[i].overrun));
    end

    // Abort after two captured rows, then a full fresh operation.
    BaseAddress = 8'h30;
    Done = 1'b1;
    set_row(500);
    step;
    set_row(504);
    step;
    Done = 1'b0;
    Error = 1'b1;
    step;
    Error = 1'b0;
    check("abort_pulse", 32'(WriteError), 32'd1);
    check("abort_ready", 32'(Ready), 32'd0);
    check("abort_no_write", 32'(MemWrite), 32'd0);
    step;
    check("abort_clear", 32'(WriteError), 32'd0);
    check("abort_ready_back", 32'(Ready), 32'd1);
    check("abort_no_write2", 32'(MemWrite), 32'd0);
    send_rows(8'h40, 200);
    run_write(8'h40, 200, 16'hFFFF, -1, -1);
    check("overrun_sticky", 32'(Overrun), 32'd1);

    // Error wins over a simultaneous Done.
    Done = 1'b1;
    Error = 1'b1;
    set_row(700);
    step;
    Done = 1'b0;
    Error = 1'b0;
    check("err_over_done", 32'(WriteError), 32'd1);
    step;

    // ClearAll in the middle of a write.
    send_rows(8'h60, 300);
    MemReady = 1'b1;
    repeat (5) step;
    check("mid_addr", 32'(MemAddress), 32'h65);
    check("mid_data", MemData, 32'd305);
    ClearAll = 1'b1;
    #1;
    check("clr_write", 32'(MemWrite), 32'd0);
    check("clr_addr", 32'(MemAddress), 32'd0);
    check("clr_data", MemData, 32'd0);
    check("clr_ovr", 32'(Overrun), 32'd0);
    check("clr_ready", 32'(Ready), 32'd1);
    step;
    ClearAll = 1'b0;
    w = 0;
    repeat (20) begin
      if (MemWrite) w++;
      step;
    end
    check("clr_no_more_writes", 32'(w), 32'd0);
    check("clr_ready_after", 32'(Ready), 32'd1);
    check("clr_done_quiet", 32'(WriteDone), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
